// File: rtl/riscv_sc_pkg.sv
// Shared definitions for the single-cycle CPU front-end blocks.
//   SC_DATA_W  : default instruction word width
//   SC_NOP     : canonical RISC-V NOP (addi x0, x0, 0)
//   ld_state_e : program-loader state encoding
package riscv_sc_pkg;

  localparam int          SC_DATA_W = 32;
  localparam logic [31:0] SC_NOP    = 32'h00000013;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    RUN   = 3'd3,
    ERROR = 3'd4
  } ld_state_e;

endpackage

// File: rtl/loader_delay_cnt.sv
// 4-bit down-counter that times the gap between the last instruction
// write and releasing the CPU.
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : force the count to zero
//   load      : load load_val (takes priority over en)
//   load_val  : value loaded on load
//   en        : decrement by one while non-zero
//   done      : count is zero
module loader_delay_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       done
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else if (clr) begin
      cnt_q <= 4'd0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign done = (cnt_q == 4'd0);

endmodule

// File: rtl/imem_program_loader.sv
// Fills the single-cycle CPU's instruction memory from a valid/ready word
// stream, then releases the core through its start line.
//   clk, rst    : clock, asynchronous active-high reset
//   load_req    : one-cycle pulse, (re)starts a load at address 0
//   in_valid/in_data/in_last/in_ready : word stream (in_last marks the end)
//   imem_we/imem_addr/imem_wdata      : instruction-memory write port,
//                                       one cycle after each handshake
//   start       : CPU run (1) / hold (0)
//   busy        : loader is in LOAD or FLUSH
//   word_count  : words written by the current/last load
//   overflow    : sticky, capacity reached without in_last
// Optional build macro IMEM_LOADER_CHECKSUM_EN: the in_last word becomes a
// checksum of the preceding words (not written, not counted); a mismatch
// parks the loader in ERROR and raises the sticky cksum_err output.
module imem_program_loader
  import riscv_sc_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = SC_DATA_W,
  parameter int MAX_WORDS   = 256,
  parameter int START_DELAY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              start,
  output logic              busy,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic              cksum_err
`endif
);

  localparam int               CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(MAX_WORDS - 1);
  // The counter is loaded on FLUSH entry and RUN follows the cycle it reads
  // zero, so START_DELAY-1 yields exactly START_DELAY FLUSH cycles.
  localparam logic [3:0]       DLY_LOAD  = 4'(START_DELAY - 1);

  ld_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             hs_p0;
  logic             wr_p0;
  logic             clr_p0;
  logic             ovf_set_p0;
  logic             dly_load_p0;
  logic             dly_en_p0;
  logic             dly_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
  logic              err_set_p0;
`endif

  assign in_ready   = (state_q == LOAD);
  assign hs_p0      = in_valid && in_ready;
  assign word_count = cnt_q;

  loader_delay_cnt u_dly (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_p0),
    .load     (dly_load_p0),
    .load_val (DLY_LOAD),
    .en       (dly_en_p0),
    .done     (dly_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // load_req overrides everything, including a coincident handshake.
  always_comb begin
    state_d     = state_q;
    wr_p0       = 1'b0;
    clr_p0      = 1'b0;
    ovf_set_p0  = 1'b0;
    dly_load_p0 = 1'b0;
    dly_en_p0   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    err_set_p0  = 1'b0;
`endif
    if (load_req) begin
      state_d = LOAD;
      clr_p0  = 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        LOAD: begin
          if (hs_p0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (in_last) begin
              if (in_data == sum_q) begin
                state_d     = FLUSH;
                dly_load_p0 = 1'b1;
              end else begin
                state_d    = ERROR;
                err_set_p0 = 1'b1;
              end
            end else
`endif
            begin
              wr_p0 = 1'b1;
              if (in_last || (cnt_q == LAST_ADDR)) begin
                state_d     = FLUSH;
                dly_load_p0 = 1'b1;
                ovf_set_p0  = !in_last;
              end
            end
          end
        end
        FLUSH: begin
          if (dly_done) state_d = RUN;
          else          dly_en_p0 = 1'b1;
        end
        RUN: ;
`ifdef IMEM_LOADER_CHECKSUM_EN
        ERROR: ;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // Stage p0 -> p1: handshake registered onto the memory write port;
  // start/busy are registered decodes of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cnt_q      <= '0;
      overflow   <= 1'b0;
      start      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      imem_we <= wr_p0;
      if (wr_p0) begin
        imem_addr  <= cnt_q[ADDR_W-1:0];
        imem_wdata <= in_data;
      end
      if (clr_p0)     cnt_q <= '0;
      else if (wr_p0) cnt_q <= cnt_q + CNT_W'(1);
      if (clr_p0)          overflow <= 1'b0;
      else if (ovf_set_p0) overflow <= 1'b1;
      start <= (state_d == RUN);
      busy  <= (state_d == LOAD) || (state_d == FLUSH);
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running wrap-around sum of the program words written so far.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q     <= '0;
      cksum_err <= 1'b0;
    end else begin
      if (clr_p0)     sum_q <= '0;
      else if (wr_p0) sum_q <= sum_q + in_data;
      if (clr_p0)          cksum_err <= 1'b0;
      else if (err_set_p0) cksum_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for imem_program_loader (MAX_WORDS=4, START_DELAY=2). A transaction
// level model predicts every output each cycle; directed scenarios add
// hand-computed literal expectations, then randomized loads follow.
module tb_imem_program_loader;

  localparam int ADDR_W      = 2;
  localparam int DATA_W      = 32;
  localparam int MAX_WORDS   = 4;
  localparam int START_DELAY = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_req = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              start;
  logic              busy;
  logic [ADDR_W:0]   word_count;
  logic              overflow;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic              cksum_err;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  int rise_cyc = 0;
  logic prev_start = 1'b0;
  int wa_q[$];
  logic [31:0] wd_q[$];

  always #5 clk = ~clk;

  imem_program_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS), .START_DELAY(START_DELAY)
  ) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .start(start), .busy(busy), .word_count(word_count),
    .overflow(overflow)
`ifdef IMEM_LOADER_CHECKSUM_EN
    , .cksum_err(cksum_err)
`endif
  );

  // Behavioural model: loading flag, remaining flush cycles, run flag.
  bit          m_loading = 0, m_run = 0, m_ovf = 0, m_err = 0, e_we = 0;
  int          m_wait = 0, m_n = 0, e_addr = 0;
  logic [31:0] m_sum = '0, e_data = '0;

  always @(posedge clk or posedge rst) begin : model
    bit ld, run, ovf, err, we;
    int wt, n, wa;
    logic [31:0] sum, wd;
    if (rst) begin
      m_loading <= 0; m_run <= 0; m_ovf <= 0; m_err <= 0; e_we <= 0;
      m_wait <= 0; m_n <= 0; e_addr <= 0; m_sum <= '0; e_data <= '0;
    end else begin
      ld = m_loading; run = m_run; ovf = m_ovf; err = m_err; we = 0;
      wt = m_wait; n = m_n; wa = e_addr; sum = m_sum; wd = e_data;
      if (load_req) begin
        ld = 1; run = 0; ovf = 0; err = 0; wt = 0; n = 0; sum = '0;
      end else if (ld && in_valid) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (in_last) begin
          ld = 0;
          if (in_data == sum) wt = START_DELAY;
          else err = 1;
        end else
`endif
        begin
          we = 1; wa = n; wd = in_data; n = n + 1; sum = sum + in_data;
          if (in_last || n == MAX_WORDS) begin
            ld = 0; wt = START_DELAY; ovf = !in_last;
          end
        end
      end else if (wt > 0) begin
        wt = wt - 1;
        if (wt == 0) run = 1;
      end
      m_loading <= ld; m_run <= run; m_ovf <= ovf; m_err <= err; e_we <= we;
      m_wait <= wt; m_n <= n; e_addr <= wa; m_sum <= sum; e_data <= wd;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'(m_loading));
      chk("start", 32'(start), 32'(m_run));
      chk("busy", 32'(busy), 32'(m_loading || (m_wait > 0)));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("imem_we", 32'(imem_we), 32'(e_we));
      chk("word_count", 32'(word_count), 32'(m_n));
      if (e_we) begin
        chk("imem_addr", 32'(imem_addr), 32'(e_addr));
        chk("imem_wdata", imem_wdata, e_data);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk("cksum_err", 32'(cksum_err), 32'(m_err));
`endif
      if (imem_we) begin
        wa_q.push_back(int'(imem_addr));
        wd_q.push_back(imem_wdata);
        last_we_cyc = cyc;
      end
      if (start && !prev_start) rise_cyc = cyc;
      prev_start = start;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    compare_outputs();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    load_req = 1'b0;
    in_last  = 1'($urandom_range(0, 1));
    in_data  = $urandom;
  endtask

  task automatic pulse_load();
    idle();
    tick();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    wa_q.delete();
    wd_q.delete();
  endtask

  // Called at a negedge; the handshake (if any) happens on the next edge.
  task automatic push(input logic [31:0] d, input bit last, input bit gaps, output bit acc);
    int g;
    g = 0;
    while (gaps && g < 4 && $urandom_range(0, 2) == 0) begin
      idle();
      tick();
      g++;
    end
    acc = m_loading;
    if (acc) begin
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      tick();
    end
  endtask

  task automatic wait_settle();
    int b;
    b = 0;
    while ((m_loading || m_wait > 0) && b < 40) begin
      idle();
      tick();
      b++;
    end
    checks++;
    if (b >= 40) begin
      errors++;
      $display("FAIL settle_timeout: got %0d cycles expected < 40", b);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit acc, gaps, last, good_ck;
    int len;
    logic [31:0] d, s;

    // Reset state
    idle();
    tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_imem_we", 32'(imem_we), 0);
    chk("rst_word_count", 32'(word_count), 0);
    tick();
    rst = 1'b0;
    tick();

`ifndef IMEM_LOADER_CHECKSUM_EN
    // Three-word program, back to back
    pulse_load();
    push(32'h00100093, 0, 0, acc);
    push(32'h00200113, 0, 0, acc);
    push(32'h002081b3, 1, 0, acc);
    idle();
    wait_settle();
    chk("t1_nwrites", wa_q.size(), 3);
    chk("t1_addr0", wa_q[0], 0);
    chk("t1_addr2", wa_q[2], 2);
    chk("t1_data2", wd_q[2], 32'h002081b3);
    chk("t1_word_count", 32'(word_count), 3);
    chk("t1_start", 32'(start), 1);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_start_lag", rise_cyc - last_we_cyc, 2);

    // Same program with valid toggling
    pulse_load();
    in_valid = 1; in_data = 32'h00100093; in_last = 0; tick();
    in_valid = 0; in_data = 32'hdeadbeef; in_last = 1; tick();
    in_valid = 1; in_data = 32'h00200113; in_last = 0; tick();
    in_valid = 0; in_data = 32'hcafef00d; in_last = 1; tick();
    in_valid = 1; in_data = 32'h002081b3; in_last = 1; tick();
    idle();
    wait_settle();
    chk("t2_nwrites", wa_q.size(), 3);
    chk("t2_addr1", wa_q[1], 1);
    chk("t2_data1", wd_q[1], 32'h00200113);
    chk("t2_start", 32'(start), 1);
`endif

    // Overflow: six words, no last
    pulse_load();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_data = $urandom; in_last = 0;
      tick();
    end
    idle();
    wait_settle();
    chk("t3_nwrites", wa_q.size(), 4);
    chk("t3_addr3", wa_q[3], 3);
    chk("t3_overflow", 32'(overflow), 1);
    chk("t3_in_ready", 32'(in_ready), 0);
    chk("t3_word_count", 32'(word_count), 4);
    chk("t3_start", 32'(start), 1);

    // Reload from RUN with a single NOP
    pulse_load();
    chk("t4_start_dropped", 32'(start), 0);
    chk("t4_ovf_cleared", 32'(overflow), 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    push(32'h00000013, 0, 0, acc);
`endif
    push(32'h00000013, 1, 0, acc);
    idle();
    wait_settle();
    chk("t4_word_count", 32'(word_count), 1);
    chk("t4_addr0", wa_q[0], 0);
    chk("t4_data0", wd_q[0], 32'h00000013);
    chk("t4_start", 32'(start), 1);

    // Asynchronous reset mid-load
    pulse_load();
    push($urandom, 0, 0, acc);
    push($urandom, 0, 0, acc);
    idle();
    #2 rst = 1'b1;
    #1;
    chk("t5_in_ready", 32'(in_ready), 0);
    chk("t5_imem_we", 32'(imem_we), 0);
    chk("t5_start", 32'(start), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_word_count", 32'(word_count), 0);
    tick();
    rst = 1'b0;
    tick();

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum match then mismatch
    pulse_load();
    push(32'd5, 0, 0, acc);
    push(32'd7, 0, 0, acc);
    push(32'd12, 1, 0, acc);
    idle();
    wait_settle();
    chk("t6_nwrites", wa_q.size(), 2);
    chk("t6_start", 32'(start), 1);
    chk("t6_cksum_ok", 32'(cksum_err), 0);
    pulse_load();
    push(32'd5, 0, 0, acc);
    push(32'd7, 0, 0, acc);
    push(32'd13, 1, 0, acc);
    idle();
    repeat (5) tick();
    chk("t6_cksum_err", 32'(cksum_err), 1);
    chk("t6_err_start", 32'(start), 0);
    chk("t6_err_busy", 32'(busy), 0);
    chk("t6_err_in_ready", 32'(in_ready), 0);
    pulse_load();
    chk("t6_err_cleared", 32'(cksum_err), 0);
    chk("t6_reload_ready", 32'(in_ready), 1);
`endif

    // Randomized loads, gaps and coincident load_req
    for (int k = 0; k < 40; k++) begin
      len = $urandom_range(1, 6);
      gaps = 1'($urandom_range(0, 1));
      good_ck = 1'($urandom_range(0, 1));
      s = '0;
      pulse_load();
      for (int i = 0; i < len; i++) begin
        d = $urandom;
        last = (i == len - 1);
        if ($urandom_range(0, 11) == 0) begin
          load_req = 1'b1; in_valid = 1'b1; in_data = d; in_last = last;
          tick();
          load_req = 1'b0;
          s = '0;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (last && good_ck) d = s;
`endif
        push(d, last, gaps, acc);
        if (!acc) break;
        s = s + d;
      end
      idle();
      wait_settle();
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Front-end that fills the single-cycle CPU's instruction memory from a valid/ready word stream, then releases the core by driving its `start` input.
- Sits between the host or bench stimulus port and `SingleCycleCPU`.
- Owns the instruction-memory write port and the `start` line, so programs are loaded by hardware rather than by `$readmemh`.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- DATA_W, 32, instruction word width.
- MAX_WORDS, 256, capacity in words; must be <= 2**ADDR_W.
- START_DELAY, 2, idle cycles between the last write and `start` rising (range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_req  input  1  one-cycle pulse; (re)starts a load from address 0.
- in_valid  input  1  stream word valid.
- in_data  input  DATA_W  stream word.
- in_last  input  1  marks final word of the program.
- in_ready  output  1  loader accepts a word this cycle.
- imem_we  output  1  instruction-memory write enable.
- imem_addr  output  ADDR_W  word address of the write.
- imem_wdata  output  DATA_W  write data.
- start  output  1  CPU start; high = run, low = hold.
- busy  output  1  high in LOAD or FLUSH.
- word_count  output  ADDR_W+1  words written in the current/last load.
- overflow  output  1  sticky; MAX_WORDS reached without in_last.

Behaviour:
- Reset, async, active-high. All outputs go to 0 immediately. State = IDLE, address counter = 0, delay counter = 0.
- States:
  - IDLE: in_ready=0, start=0. load_req -> LOAD.
  - LOAD: in_ready=1. A handshake is in_valid && in_ready.
  - FLUSH: counts START_DELAY cycles, then -> RUN.
  - RUN: start=1, in_ready=0.
  - ERROR: only exists with CHECKSUM_EN.
- Write latency is 1 cycle. Handshake at edge N gives imem_we=1 during cycle N+1, with imem_addr = the counter value at the handshake and imem_wdata = in_data. imem_we is otherwise 0.
- Address counter increments on each handshake. word_count = counter value, registered.
- LOAD exit:
  - A handshake with in_last=1 -> FLUSH.
  - A handshake at address MAX_WORDS-1 with in_last=0 -> FLUSH and overflow<=1. Further stream words are not accepted.
- On entering LOAD from load_req: counter, word_count, overflow and the delay counter are cleared.
- FLUSH: start stays low. On the START_DELAY-th cycle after entry, the state becomes RUN. start rises on the edge that enters RUN and stays high until load_req or rst.
- load_req while in RUN: start drops on the next edge; state -> LOAD.
- load_req while in LOAD or FLUSH: restart from address 0. A handshake coinciding with load_req is discarded (no write).
- busy = state is LOAD or FLUSH (registered decode).
- in_valid without in_ready: data is ignored, no state change. in_last is meaningful only during a handshake.
- rst in mid-load: abort immediately. Memory contents already written are undefined to the CPU; start=0.

Optional Feature:
- Macro: `IMEM_LOADER_CHECKSUM_EN`.
- Enabled:
  - The word carrying in_last is a checksum. It is not written (no imem_we) and is not counted.
  - The loader keeps a running 32-bit wrap-around sum of all prior words in the load.
  - Match -> FLUSH.
  - Mismatch -> ERROR: start=0, busy=0, in_ready=0. Only load_req or rst leaves ERROR.
  - Output port `cksum_err` (1 bit, sticky until the next load_req or rst) is added.
- Disabled: no ERROR state, no cksum_err port. The in_last word is a program word.

Decomposition:
- Shared package `riscv_sc_pkg`:
  - state encoding typedef: IDLE=0, LOAD=1, FLUSH=2, RUN=3, ERROR=4.
  - DATA_W default and the NOP constant 32'h00000013.
- Sub-module `loader_delay_cnt`: 4-bit down-counter with load/done. Used for FLUSH.
- Everything else stays in one module.

Test Plan:
1. rst=1 then 0, then load_req. Stream 3 words: 32'h00100093, 32'h00200113, 32'h002081b3 (last) -> imem writes at addr 0,1,2; word_count=3; start rises exactly 2 cycles after the write at addr 2; busy falls with it.
2. Same 3-word program with in_valid toggled 1,0,1,0,1 -> writes stay contiguous at addr 0..2; in_ready=1 throughout LOAD; no write in the idle cycles.
3. MAX_WORDS=4, stream 6 words with no in_last -> 4 writes (addr 0..3); overflow=1; in_ready=0 after the 4th word; start=1.
4. In RUN, pulse load_req, then stream 1 word 32'h00000013 (last) -> start=0 the next cycle; write at addr 0; word_count=1; overflow cleared; start high again after START_DELAY.
5. Assert rst asynchronously mid-load after 2 handshakes -> in_ready, imem_we, start, busy go to 0 before the next edge; word_count=0.
6. With IMEM_LOADER_CHECKSUM_EN: words 5, 7, then last 12 -> 2 writes and start=1. Repeat with last 13 -> cksum_err=1, start stays 0, state ERROR until load_req.
